// File: rtl/uart_tx_pkg.sv
// Shared constants and state encoding for the UART transmitter.
package uart_tx_pkg;

   localparam int TICKS_PER_BIT = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop period.
// Optional parity bit is built in when UART_TX_PARITY_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | line high, waiting for i_tx_start
// ST_START  | driving start bit (low) for one bit period
// ST_DATA   | driving shreg[0], NB_DATA bit periods
// ST_PARITY | driving even parity of the latched word
// ST_STOP   | line high for N_TICKS_TO_STOP ticks, then done pulse
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int NB_DATA         = 8,
   parameter int NB_STATE        = 3,
   parameter int NB_COUNT        = 4,
   parameter int NB_DATA_COUNT   = 4,
   parameter int N_TICKS_TO_STOP = 16
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic               i_tx_start,
   input  logic [NB_DATA-1:0] i_data,
   output logic               o_tx,
   output logic               o_tx_done_tick,
   output logic               o_busy
);

   // Counter must also hold the stop period, which may span two bit times.
   localparam int CNT_W = (NB_COUNT > $clog2(N_TICKS_TO_STOP)) ? NB_COUNT : $clog2(N_TICKS_TO_STOP);
   localparam logic [CNT_W-1:0]         BIT_LAST  = CNT_W'(TICKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]         STOP_LAST = CNT_W'(N_TICKS_TO_STOP - 1);
   localparam logic [NB_DATA_COUNT-1:0] IDX_LAST  = NB_DATA_COUNT'(NB_DATA - 1);

   if (NB_STATE != $bits(state_e)) begin : g_bad_state_width
      $error("NB_STATE does not match the state encoding width");
   end

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [NB_DATA_COUNT-1:0] idx_q, idx_d;
   logic [NB_DATA-1:0]       shreg_q, shreg_d;
   logic                     tx_q, tx_d;
   logic                     done_q, done_d;
   logic                     busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
   logic                     par_q, par_d;
`endif

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Timing uses a down-counter; each state ends on the tick seen at terminal count zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_tx_start) begin
               shreg_d = i_data;
               cnt_d   = BIT_LAST;
               state_d = ST_START;
`ifdef UART_TX_PARITY_EN
               par_d   = ^i_data;
`endif
            end
         end
         ST_START: begin
            if (i_tick) begin
               if (cnt_q == '0) begin
                  cnt_d   = BIT_LAST;
                  idx_d   = '0;
                  state_d = ST_DATA;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (i_tick) begin
               if (cnt_q == '0) begin
                  cnt_d   = BIT_LAST;
                  shreg_d = shreg_q >> 1;
                  if (idx_q == IDX_LAST) begin
                     idx_d = '0;
`ifdef UART_TX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     cnt_d   = STOP_LAST;
                     state_d = ST_STOP;
`endif
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (i_tick) begin
               if (cnt_q == '0) begin
                  cnt_d   = STOP_LAST;
                  state_d = ST_STOP;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (i_tick) begin
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the line is registered with the state.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   assign o_tx           = tx_q;
   assign o_tx_done_tick = done_q;
   assign o_busy         = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, random words against a frame model, corner sequences.
module tb_uart_tx;

   localparam int TICK_DIV = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       i_clock    = 1'b0;
   logic       i_reset    = 1'b0;
   logic       i_tick     = 1'b0;
   logic       i_tx_start = 1'b0;
   logic [7:0] i_data     = 8'h00;
   logic       o_tx;
   logic       o_tx_done_tick;
   logic       o_busy;

   int checks     = 0;
   int errors     = 0;
   int tick_total = 0;
   int done_cnt   = 0;

   typedef struct {
      logic [7:0] data;
      logic [9:0] exp_frame;
      logic       exp_par;
      int         pre_dly;
      bit         glitch;
   } vec_t;

   vec_t vecs [7];

   uart_tx dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_tick         (i_tick),
      .i_tx_start     (i_tx_start),
      .i_data         (i_data),
      .o_tx           (o_tx),
      .o_tx_done_tick (o_tx_done_tick),
      .o_busy         (o_busy)
   );

   always #10 i_clock = ~i_clock;

   initial begin
      int div;
      div = 0;
      forever begin
         @(negedge i_clock);
         div = (div + 1) % TICK_DIV;
         i_tick = (div == 0);
      end
   end

   always @(posedge i_clock) if (i_tick) tick_total <= tick_total + 1;
   always @(negedge i_clock) if (o_tx_done_tick) done_cnt <= done_cnt + 1;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ticks_to(input int target);
      int g;
      g = 0;
      while (tick_total < target) begin
         @(posedge i_clock);
         #1;
         g++;
         if (g > 4000) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got %0d ticks expected %0d", tick_total, target);
            break;
         end
      end
   endtask

   // Frame model: start 0, data LSB first, optional even parity, stop 1.
   function automatic logic [11:0] model_frame(input logic [7:0] d);
      logic [11:0] v;
      int ones;
      int b;
      v    = '0;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         b = (int'(d) / (1 << i)) % 2;
         v[1 + i] = b[0];
         ones += b;
      end
`ifdef UART_TX_PARITY_EN
      v[9]  = ones % 2;
      v[10] = 1'b1;
`else
      v[9]  = 1'b1;
`endif
      return v;
   endfunction

   function automatic logic [11:0] table_frame(input logic [9:0] f, input logic p);
`ifdef UART_TX_PARITY_EN
      return {1'b0, f[9], p, f[8:0]};
`else
      return {2'b00, f};
`endif
   endfunction

   // Optionally pulses start, then checks every bit mid-period and the done pulse at stop end.
   task automatic run_frame(input logic [7:0] d, input logic [11:0] exp, input bit pulse,
                            input bit glitch, input bit hold, input string tag);
      int base;
      int d0;
      d0 = done_cnt;
      if (pulse) begin
         @(negedge i_clock);
         i_data     = d;
         i_tx_start = 1'b1;
         @(posedge i_clock);
         #1;
      end
      i_tx_start = hold;
      base = tick_total;
      check({tag, "_accept_busy"}, o_busy, 1'b1);
      check({tag, "_accept_tx"}, o_tx, 1'b0);
      if (!hold) i_data = ~d;
      for (int i = 0; i < NBITS; i++) begin
         wait_ticks_to(base + 8 + 16 * i);
         check($sformatf("%s_bit%0d", tag, i), o_tx, exp[i]);
         if (glitch && i == 4) begin
            i_data     = 8'hFF;
            i_tx_start = 1'b1;
            @(posedge i_clock);
            #1;
            i_tx_start = 1'b0;
            check({tag, "_glitch_busy"}, o_busy, 1'b1);
         end
      end
      wait_ticks_to(base + 16 * NBITS);
      check({tag, "_done"}, o_tx_done_tick, 1'b1);
      check({tag, "_done_busy"}, o_busy, 1'b0);
      check({tag, "_done_tx"}, o_tx, 1'b1);
      @(posedge i_clock);
      #1;
      check({tag, "_done_width"}, o_tx_done_tick, 1'b0);
      check({tag, "_done_count"}, done_cnt, d0 + 1);
      check({tag, "_after_busy"}, o_busy, hold);
   endtask

   initial begin
      int d0;
      logic [7:0] rd;

      vecs[0] = '{8'hBD, 10'b1101111010, 1'b0, 0, 1'b0};
      vecs[1] = '{8'h81, 10'b1100000010, 1'b0, 1, 1'b1};
      vecs[2] = '{8'h00, 10'b1000000000, 1'b0, 2, 1'b0};
      vecs[3] = '{8'hFF, 10'b1111111110, 1'b0, 3, 1'b0};
      vecs[4] = '{8'h01, 10'b1000000010, 1'b1, 0, 1'b0};
      vecs[5] = '{8'h07, 10'b1000001110, 1'b1, 2, 1'b0};
      vecs[6] = '{8'h3C, 10'b1001111000, 1'b0, 1, 1'b0};

      // Reset held, then idle with ticks running.
      #1us;
      check("reset_tx", o_tx, 1'b1);
      check("reset_busy", o_busy, 1'b0);
      check("reset_done", o_tx_done_tick, 1'b0);
      @(negedge i_clock);
      i_reset = 1'b1;
      repeat (300) @(posedge i_clock);
      #1;
      check("idle_tx", o_tx, 1'b1);
      check("idle_busy", o_busy, 1'b0);
      check("idle_done_count", done_cnt, 0);

      for (int v = 0; v < 7; v++) begin
         repeat (vecs[v].pre_dly) @(posedge i_clock);
         run_frame(vecs[v].data, table_frame(vecs[v].exp_frame, vecs[v].exp_par), 1'b1,
                   vecs[v].glitch, 1'b0, $sformatf("vec%0d", v));
      end

      // Back-to-back frames with start held high.
      @(negedge i_clock);
      i_data     = 8'h55;
      i_tx_start = 1'b1;
      @(posedge i_clock);
      #1;
      run_frame(8'h55, model_frame(8'h55), 1'b0, 1'b0, 1'b1, "btb1");
      run_frame(8'h55, model_frame(8'h55), 1'b0, 1'b0, 1'b0, "btb2");

      // Reset in the middle of data bit 3.
      begin
         int base;
         d0 = done_cnt;
         @(negedge i_clock);
         i_data     = 8'h00;
         i_tx_start = 1'b1;
         @(posedge i_clock);
         #1;
         i_tx_start = 1'b0;
         base = tick_total;
         wait_ticks_to(base + 16 + 16 * 3 + 8);
         check("abort_pre_tx", o_tx, 1'b0);
         #3;
         i_reset = 1'b0;
         #1;
         check("abort_tx", o_tx, 1'b1);
         check("abort_busy", o_busy, 1'b0);
         check("abort_done", o_tx_done_tick, 1'b0);
         repeat (5) @(posedge i_clock);
         @(negedge i_clock);
         i_reset = 1'b1;
         wait_ticks_to(tick_total + 200);
         check("abort_no_done", done_cnt, d0);
         check("abort_idle_tx", o_tx, 1'b1);
         run_frame(8'hA5, model_frame(8'hA5), 1'b1, 1'b0, 1'b0, "after_abort");
      end

      for (int r = 0; r < 16; r++) begin
         rd = 8'($urandom);
         repeat ($urandom_range(0, 7)) @(posedge i_clock);
         run_frame(rd, model_frame(rd), 1'b1, 1'b0, 1'b0, $sformatf("rand%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
